ne16_normquant_outpack: RTL and testbench

Downstream stage of the normquant bias/shift block. Takes one bank of NADD normalized 32-bit lanes and applies optional ReLU and saturation to 8-bit or 32-bit. Serializes the result as a stream of 32-bit words with byte strobes for the streamer/output buffer. One bank is buffered at a time, with valid/ready on both sides.

---
 rtl/ne16_package.sv | 18 +
 rtl/ne16_outpack_sat.sv | 31 +++
 rtl/ne16_normquant_outpack.sv | 135 +++++++++++++
 tb/tb_ne16_normquant_outpack.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ne16_package.sv
// Shared types for the NE16 normquant output packer.
package ne16_package;

  localparam int unsigned NE16_NADD         = 8;
  localparam int unsigned NE16_OUTPACK_WORD = 32;

  typedef enum logic {
    QUANT_8  = 1'b0,
    QUANT_32 = 1'b1
  } quant_mode_t;

  typedef struct packed {
    quant_mode_t                        quant_mode;
    logic                               relu;
    logic [$clog2(NE16_NADD+1)-1:0]     n_lanes;
  } ctrl_outpack_t;

endpackage

// File: rtl/ne16_outpack_sat.sv
// Per-lane ReLU and saturation; 8-bit results are returned zero-extended in the low byte.
module ne16_outpack_sat
  import ne16_package::*;
(
  input  logic [31:0] x_i,
  input  quant_mode_t quant_mode_i,
  input  logic        relu_i,
  output logic [31:0] y_o
);

  logic signed [31:0] xs;
  assign xs = x_i;

  always_comb begin
    y_o = x_i;
    if (quant_mode_i == QUANT_8) begin
      if (relu_i) begin
        if (xs < 32'sd0)        y_o = 32'h0000_0000;
        else if (xs > 32'sd255) y_o = 32'h0000_00FF;
        else                    y_o = {24'h0, x_i[7:0]};
      end else begin
        if (xs > 32'sd127)       y_o = 32'h0000_007F;
        else if (xs < -32'sd128) y_o = 32'h0000_0080;
        else                     y_o = {24'h0, x_i[7:0]};
      end
    end else if (relu_i && (xs < 32'sd0)) begin
      y_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/ne16_normquant_outpack.sv
// Buffers one saturated bank of lanes and streams it out as 32-bit words with byte strobes.
module ne16_normquant_outpack
  import ne16_package::*;
#(
  parameter int unsigned NADD = NE16_NADD,
  parameter int unsigned ACC  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [NADD*ACC-1:0] data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  ctrl_outpack_t       ctrl_i,
  output logic [31:0]         out_data_o,
  output logic [3:0]          out_strb_o,
  output logic                out_last_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  if (ACC != 32) begin : g_bad_acc
    $error("ne16_normquant_outpack: ACC must be 32");
  end
  if ((NADD < 4) || ((NADD % 4) != 0)) begin : g_bad_nadd
    $error("ne16_normquant_outpack: NADD must be a multiple of 4 and >= 4");
  end

  localparam int unsigned NW_W = $clog2(NADD+1);
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SEND = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [NW_W-1:0]            cnt_q, cnt_d;
  logic [NW_W-1:0]            nwords_q, nwords_d;
  logic [NW_W-1:0]            n_q, n_d;
  quant_mode_t                mode_q, mode_d;
  logic [NADD-1:0][ACC-1:0]   bank_q, bank_d;
  logic [NADD-1:0][ACC-1:0]   sat_lane;
  logic [31:0]                n_eff;
  logic [31:0]                nwords_eff;
  logic                       in_hs, out_hs, last_word;

  for (genvar i = 0; i < NADD; i++) begin : g_sat
    ne16_outpack_sat u_sat (
      .x_i         (data_i[i*ACC +: ACC]),
      .quant_mode_i(ctrl_i.quant_mode),
      .relu_i      (ctrl_i.relu),
      .y_o         (sat_lane[i])
    );
  end

  // n_lanes of 0 or beyond NADD selects the full bank.
  always_comb begin
    n_eff = 32'(ctrl_i.n_lanes);
    if ((n_eff == 32'd0) || (n_eff > 32'(NADD))) n_eff = 32'(NADD);
    nwords_eff = (ctrl_i.quant_mode == QUANT_8) ? ((n_eff + 32'd3) >> 2) : n_eff;
  end

  assign in_ready_o  = (state_q == STATE_IDLE);
  assign out_valid_o = (state_q == STATE_SEND);
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_hs      = out_valid_o & out_ready_i;
  assign last_word   = (cnt_q == (nwords_q - NW_W'(1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nwords_d = nwords_q;
    n_d      = n_q;
    mode_d   = mode_q;
    bank_d   = bank_q;
    if (state_q == STATE_IDLE) begin
      if (in_hs) begin
        state_d  = STATE_SEND;
        cnt_d    = '0;
        nwords_d = NW_W'(nwords_eff);
        n_d      = NW_W'(n_eff);
        mode_d   = ctrl_i.quant_mode;
        for (int i = 0; i < int'(NADD); i++) begin
          bank_d[i] = (32'(i) < n_eff) ? sat_lane[i] : '0;
        end
      end
    end else if (out_hs) begin
      if (last_word) state_d = STATE_IDLE;
      else           cnt_d   = cnt_q + NW_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= STATE_IDLE;
      cnt_q    <= '0;
      nwords_q <= '0;
      n_q      <= '0;
      mode_q   <= QUANT_8;
      bank_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nwords_q <= nwords_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      bank_q   <= bank_d;
    end
  end

  // Output word selected by the counter; bytes past the lane count stay zero.
  always_comb begin
    out_data_o = '0;
    out_strb_o = '0;
    out_last_o = 1'b0;
    if (state_q == STATE_SEND) begin
      out_last_o = last_word;
      if (mode_q == QUANT_8) begin
        for (int k = 0; k < int'(NADD/4); k++) begin
          if (cnt_q == NW_W'(k)) begin
            for (int b = 0; b < 4; b++) begin
              out_data_o[8*b +: 8] = bank_q[4*k+b][7:0];
              out_strb_o[b]        = (int'(n_q) > (4*k + b));
            end
          end
        end
      end else begin
        for (int k = 0; k < int'(NADD); k++) begin
          if (cnt_q == NW_W'(k)) begin
            out_data_o = bank_q[k];
            out_strb_o = 4'hF;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ne16_normquant_outpack.sv
// Directed table-driven bench for the output packer plus reset/clear/backpressure sequences.
module tb_ne16_normquant_outpack;
  import ne16_package::*;

  logic              clk = 1'b0;
  logic              rst, clear;
  logic [8*32-1:0]   data;
  logic              in_valid, in_ready;
  ctrl_outpack_t     ctrl;
  logic [31:0]       out_data;
  logic [3:0]        out_strb;
  logic              out_last, out_valid, out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ne16_normquant_outpack #(.NADD(8), .ACC(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .data_i     (data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ctrl_i     (ctrl),
    .out_data_o (out_data),
    .out_strb_o (out_strb),
    .out_last_o (out_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  typedef struct {
    logic [7:0][31:0] lanes;
    quant_mode_t      mode;
    logic             relu;
    logic [3:0]       n;
    int               nw;
    logic [7:0][31:0] w;
    logic [7:0][3:0]  s;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " data"}, out_data, 32'd0);
    check({tag, " strb"}, 32'(out_strb), 32'd0);
    check({tag, " last"}, 32'(out_last), 32'd0);
  endtask

  task automatic present(input vec_t v);
    data            = v.lanes;
    ctrl.quant_mode = v.mode;
    ctrl.relu       = v.relu;
    ctrl.n_lanes    = v.n;
    in_valid        = 1'b1;
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the last word.
  task automatic send_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    present(v);
    out_ready = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < v.nw; k++) begin
      check($sformatf("%s w%0d valid", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s w%0d data", tag, k), out_data, v.w[k]);
      check($sformatf("%s w%0d strb", tag, k), 32'(out_strb), 32'(v.s[k]));
      check($sformatf("%s w%0d last", tag, k), 32'(out_last), 32'(k == v.nw - 1));
      check($sformatf("%s w%0d in_ready", tag, k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, " end valid"}, 32'(out_valid), 32'd0);
    check({tag, " end in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // QUANT_8, relu=0, n=8
    vecs[0].lanes = {32'd1, 32'd0, -32'sd128, 32'd127, -32'sd5, 32'd5, -32'sd300, 32'd300};
    vecs[0].mode = QUANT_8; vecs[0].relu = 1'b0; vecs[0].n = 4'd8; vecs[0].nw = 2;
    vecs[0].w = '0; vecs[0].w[0] = 32'hFB05_807F; vecs[0].w[1] = 32'h0100_807F;
    vecs[0].s = '0; vecs[0].s[0] = 4'hF; vecs[0].s[1] = 4'hF;
    // QUANT_8, relu=1, n=5; lanes 5..7 must be masked
    vecs[1].lanes = {32'd1000, 32'd1000, 32'd1000, 32'd9, 32'd3, 32'd200, 32'd256, -32'sd7};
    vecs[1].mode = QUANT_8; vecs[1].relu = 1'b1; vecs[1].n = 4'd5; vecs[1].nw = 2;
    vecs[1].w = '0; vecs[1].w[0] = 32'h03C8_FF00; vecs[1].w[1] = 32'h0000_0009;
    vecs[1].s = '0; vecs[1].s[0] = 4'hF; vecs[1].s[1] = 4'h1;
    // QUANT_32, relu=1, n=3
    vecs[2].lanes = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd42, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    vecs[2].mode = QUANT_32; vecs[2].relu = 1'b1; vecs[2].n = 4'd3; vecs[2].nw = 3;
    vecs[2].w = '0; vecs[2].w[0] = 32'd0; vecs[2].w[1] = 32'h7FFF_FFFF; vecs[2].w[2] = 32'd42;
    vecs[2].s = '0; vecs[2].s[0] = 4'hF; vecs[2].s[1] = 4'hF; vecs[2].s[2] = 4'hF;
    // QUANT_8, relu=0, n=3: partial strobe in a single word
    vecs[3].lanes = {32'd55, 32'd55, 32'd55, 32'd55, 32'd55, -32'sd129, 32'd128, -32'sd1};
    vecs[3].mode = QUANT_8; vecs[3].relu = 1'b0; vecs[3].n = 4'd3; vecs[3].nw = 1;
    vecs[3].w = '0; vecs[3].w[0] = 32'h0080_7FFF;
    vecs[3].s = '0; vecs[3].s[0] = 4'h7;
    // QUANT_8, relu=1, n=12 -> full bank
    vecs[4].lanes = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[4].mode = QUANT_8; vecs[4].relu = 1'b1; vecs[4].n = 4'd12; vecs[4].nw = 2;
    vecs[4].w = '0; vecs[4].w[0] = 32'h0403_0201; vecs[4].w[1] = 32'h0807_0605;
    vecs[4].s = '0; vecs[4].s[0] = 4'hF; vecs[4].s[1] = 4'hF;
    // QUANT_32, relu=0, n=0 -> full bank, negatives pass through
    vecs[5].lanes = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, -32'sd5};
    vecs[5].mode = QUANT_32; vecs[5].relu = 1'b0; vecs[5].n = 4'd0; vecs[5].nw = 8;
    vecs[5].w = vecs[5].lanes;
    vecs[5].s = '1;

    rst = 1'b1; clear = 1'b0; data = '0; in_valid = 1'b0; out_ready = 1'b1;
    ctrl = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post-reset");

    for (int i = 0; i < 6; i++) send_vec(vecs[i], i);

    // Backpressure on word 1, with the next bank waiting behind it.
    present(vecs[0]);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp w0 data", out_data, 32'hFB05_807F);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp hold%0d data", c), out_data, 32'h0100_807F);
      check($sformatf("bp hold%0d strb", c), 32'(out_strb), 32'hF);
      check($sformatf("bp hold%0d last", c), 32'(out_last), 32'd1);
      check($sformatf("bp hold%0d valid", c), 32'(out_valid), 32'd1);
      if (c == 2) present(vecs[2]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp release data", out_data, 32'h0100_807F);
    check("bp release in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp bubble valid", 32'(out_valid), 32'd0);
    check("bp bubble in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp next w%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp next w%0d data", k), out_data, vecs[2].w[k]);
      @(negedge clk);
    end
    check("bp next end valid", 32'(out_valid), 32'd0);

    // Reset mid-SEND drops the bank.
    present(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst mid w0 valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst mid");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst mid quiet%0d", c), 32'(out_valid), 32'd0);
    end

    // Clear on the same edge as in_valid: nothing captured.
    present(vecs[2]);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check_idle("clr capture");
    @(negedge clk);
    check("clr capture quiet", 32'(out_valid), 32'd0);

    // Clear during word 0 of a QUANT_32 bank.
    present(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("clr mid w0 valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    out_ready = 1'b1;
    check_idle("clr mid");
    @(negedge clk);
    check("clr mid quiet", 32'(out_valid), 32'd0);

    // Block still usable afterwards.
    send_vec(vecs[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
